// File: rtl/demux_1ton_param_if.sv
// Bundle of the word-stream input and the lane outputs of the 1-to-N demultiplexer.
// The master side drives the stream; the slave side is the demux itself.
interface demux_1ton_param_if #(
  parameter int DATA_W  = 8,
  parameter int N_LANES = 4
);
  localparam int SEL_W = $clog2(N_LANES);

  logic                        valid_in;
  logic [DATA_W-1:0]           data_in;
  logic                        mode;
  logic [N_LANES-1:0]          valid_out;
  logic [N_LANES*DATA_W-1:0]   data_out;
  logic [SEL_W-1:0]            lane_ptr;
  logic                        frame_done;

  modport master (
    output valid_in, data_in, mode,
    input  valid_out, data_out, lane_ptr, frame_done
  );

  modport slave (
    input  valid_in, data_in, mode,
    output valid_out, data_out, lane_ptr, frame_done
  );
endinterface

// File: rtl/demux_1ton_param.sv
// Parametrised 1-to-N word demultiplexer: round-robin forwarding to one lane per word,
// or gathering N_LANES words and releasing them on all lanes in the same cycle.
module demux_1ton_param #(
  parameter int DATA_W  = 8,
  parameter int N_LANES = 4
) (
  input logic               clk,
  input logic               reset_L,
  demux_1ton_param_if.slave bus
);
  localparam int              SEL_W = $clog2(N_LANES);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_LANES - 1);

  logic [SEL_W-1:0]          r_lanePtr;
  logic [N_LANES-1:0]        r_validOut;
  logic [N_LANES*DATA_W-1:0] r_dataOut;
  logic [DATA_W-1:0]         r_stage [N_LANES-1];
  logic                      r_modeQ;
  logic                      r_frameDone;

  logic                      w_effMode;
  logic                      w_atLast;
  logic [SEL_W-1:0]          w_nextPtr;
  logic [N_LANES-1:0]        w_oneHot;

  // A mode request only takes effect when a new frame starts at lane 0.
  assign w_effMode = (r_lanePtr == '0) ? bus.mode : r_modeQ;
  assign w_atLast  = (r_lanePtr == LAST);
  assign w_nextPtr = w_atLast ? '0 : r_lanePtr + 1'b1;
  assign w_oneHot  = {{(N_LANES-1){1'b0}}, 1'b1} << r_lanePtr;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_lanePtr   <= '0;
      r_validOut  <= '0;
      r_dataOut   <= '0;
      r_modeQ     <= 1'b0;
      r_frameDone <= 1'b0;
      for (int i = 0; i < N_LANES-1; i++) r_stage[i] <= '0;
    end else begin
      r_modeQ     <= w_effMode;
      r_frameDone <= bus.valid_in && w_atLast;
      r_validOut  <= '0;
      if (bus.valid_in) begin
        r_lanePtr <= w_nextPtr;
        if (!w_effMode) begin
          r_validOut <= w_oneHot;
          for (int i = 0; i < N_LANES; i++)
            if (r_lanePtr == SEL_W'(i)) r_dataOut[i*DATA_W +: DATA_W] <= bus.data_in;
        end else if (w_atLast) begin
          // The last word bypasses staging so the whole frame leaves one cycle after it.
          r_validOut <= '1;
          for (int i = 0; i < N_LANES-1; i++) r_dataOut[i*DATA_W +: DATA_W] <= r_stage[i];
          r_dataOut[(N_LANES-1)*DATA_W +: DATA_W] <= bus.data_in;
        end else begin
          for (int i = 0; i < N_LANES-1; i++)
            if (r_lanePtr == SEL_W'(i)) r_stage[i] <= bus.data_in;
        end
      end
    end
  end

  assign bus.valid_out  = r_validOut;
  assign bus.data_out   = r_dataOut;
  assign bus.lane_ptr   = r_lanePtr;
  assign bus.frame_done = r_frameDone;
endmodule

// File: tb/tb_demux_1ton_param.sv
// Scoreboard bench for demux_1ton_param (DATA_W=8, N_LANES=4): directed words push expected
// lane strobes into a queue, and a monitor pops and compares each strobe the DUT presents.
module tb_demux_1ton_param;
  logic clk;
  logic reset_L;
  int   total = 0;
  int   bad   = 0;

  typedef struct packed {
    logic [3:0]  v;
    logic [31:0] d;
    logic        fd;
  } exp_t;
  exp_t expQ[$];

  demux_1ton_param_if #(.DATA_W(8), .N_LANES(4)) bus ();

  demux_1ton_param #(.DATA_W(8), .N_LANES(4)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic m);
    @(negedge clk);
    bus.valid_in = v;
    bus.data_in  = d;
    bus.mode     = m;
  endtask

  task automatic pushExp(input logic [3:0] v, input logic [31:0] d, input logic fd);
    expQ.push_back('{v: v, d: d, fd: fd});
  endtask

  task automatic checkPtr(input string name, input logic [1:0] req);
    @(posedge clk);
    #1;
    checkOutput(name, 32'(bus.lane_ptr), 32'(req));
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_vld"}, 32'(bus.valid_out), 32'h0);
    checkOutput({name, "_dat"}, bus.data_out, 32'h0);
    checkOutput({name, "_ptr"}, 32'(bus.lane_ptr), 32'h0);
    checkOutput({name, "_fd"}, 32'(bus.frame_done), 32'h0);
  endtask

  // Monitor: every strobe or frame pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset_L === 1'b1 && ((|bus.valid_out) === 1'b1 || bus.frame_done === 1'b1)) begin
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL sb_unexpected: got vld=%b dat=%h fd=%b expected no output",
                 bus.valid_out, bus.data_out, bus.frame_done);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        if (bus.valid_out !== e.v || bus.data_out !== e.d || bus.frame_done !== e.fd) begin
          bad++;
          $display("[TB] FAIL sb_compare: got vld=%b dat=%h fd=%b expected vld=%b dat=%h fd=%b",
                   bus.valid_out, bus.data_out, bus.frame_done, e.v, e.d, e.fd);
        end
      end
    end
  end

  initial begin
    reset_L      = 1'b0;
    bus.valid_in = 1'b0;
    bus.data_in  = 8'h00;
    bus.mode     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_L = 1'b1;
    #1;
    checkAllZero("init");

    // Round-robin back-to-back
    applyStimulus(1, 8'h10, 0); pushExp(4'b0001, 32'h00000010, 0); checkPtr("rr_ptr1", 2'd1);
    applyStimulus(1, 8'h12, 0); pushExp(4'b0010, 32'h00001210, 0); checkPtr("rr_ptr2", 2'd2);
    applyStimulus(1, 8'h0A, 0); pushExp(4'b0100, 32'h000A1210, 0); checkPtr("rr_ptr3", 2'd3);
    applyStimulus(1, 8'h14, 0); pushExp(4'b1000, 32'h140A1210, 1); checkPtr("rr_ptr0", 2'd0);
    applyStimulus(0, 8'hEE, 0);

    // Round-robin with idle gaps, then finish the frame
    applyStimulus(1, 8'h10, 0); pushExp(4'b0001, 32'h140A1210, 0); checkPtr("gap_ptr_a", 2'd1);
    applyStimulus(0, 8'h77, 0); checkPtr("gap_ptr_b", 2'd1);
    applyStimulus(0, 8'h66, 0); checkPtr("gap_ptr_c", 2'd1);
    checkOutput("gap_lane0", 32'(bus.data_out[7:0]), 32'h10);
    applyStimulus(1, 8'h12, 0); pushExp(4'b0010, 32'h140A1210, 0); checkPtr("gap_ptr_d", 2'd2);
    applyStimulus(1, 8'h20, 0); pushExp(4'b0100, 32'h14201210, 0);
    applyStimulus(1, 8'h30, 0); pushExp(4'b1000, 32'h30201210, 1);
    applyStimulus(0, 8'h00, 0);

    // Asynchronous reset mid-clock with valid_in high
    @(posedge clk);
    #2;
    bus.valid_in = 1'b1;
    bus.data_in  = 8'h55;
    reset_L      = 1'b0;
    #1;
    checkAllZero("rst_now");
    @(posedge clk);
    @(posedge clk);
    #1;
    checkAllZero("rst_hold");
    @(negedge clk);
    reset_L      = 1'b1;
    bus.valid_in = 1'b0;
    @(posedge clk);
    #1;
    checkAllZero("rst_rel");

    // Gather frame
    applyStimulus(1, 8'h10, 1); checkPtr("g_ptr1", 2'd1);
    applyStimulus(1, 8'h12, 1); checkPtr("g_ptr2", 2'd2);
    applyStimulus(1, 8'h0A, 1); checkPtr("g_ptr3", 2'd3);
    applyStimulus(1, 8'h14, 1); pushExp(4'b1111, 32'h140A1210, 1); checkPtr("g_ptr0", 2'd0);
    applyStimulus(0, 8'h00, 1);

    // Mode raised after two round-robin words only takes effect at the next frame
    applyStimulus(1, 8'h21, 0); pushExp(4'b0001, 32'h140A1221, 0);
    applyStimulus(1, 8'h22, 0); pushExp(4'b0010, 32'h140A2221, 0);
    applyStimulus(1, 8'h23, 1); pushExp(4'b0100, 32'h14232221, 0);
    applyStimulus(1, 8'h24, 1); pushExp(4'b1000, 32'h24232221, 1);
    applyStimulus(1, 8'h25, 1);
    applyStimulus(1, 8'h26, 1);
    applyStimulus(1, 8'h27, 1);
    applyStimulus(1, 8'h28, 1); pushExp(4'b1111, 32'h28272625, 1); checkPtr("dm_ptr", 2'd0);
    applyStimulus(0, 8'h00, 1);

    // Reset in the middle of a gather frame discards the partial frame
    applyStimulus(1, 8'hAA, 1);
    applyStimulus(1, 8'hBB, 1); checkPtr("mg_ptr", 2'd2);
    @(negedge clk);
    bus.valid_in = 1'b0;
    reset_L      = 1'b0;
    #1;
    checkOutput("mg_rst_ptr", 32'(bus.lane_ptr), 32'h0);
    checkOutput("mg_rst_dat", bus.data_out, 32'h0);
    @(negedge clk);
    reset_L = 1'b1;
    applyStimulus(1, 8'h01, 1);
    applyStimulus(1, 8'h02, 1);
    applyStimulus(1, 8'h03, 1);
    applyStimulus(1, 8'h04, 1); pushExp(4'b1111, 32'h04030201, 1);
    applyStimulus(0, 8'h00, 1);

    repeat (4) @(posedge clk);
    #1;
    checkOutput("sb_drain", 32'(expQ.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
